// File: rtl/cheshire_video_frame_monitor.sv
// cheshire_video_frame_monitor
// Per-frame checker for a parallel hsync/vsync/RGB video stream on the pixel
// clock. Line and frame timing are recovered from the sync edges, a CRC-32
// (ISO-HDLC) is accumulated over a programmable active window, and a
// registered result record is emitted once per completed frame.
//
// Optional feature: define CHESHIRE_VMON_LINE_CHECK_EN to compare every line
// length in a frame against the first line of that frame (err_code_o[1]).
module cheshire_video_frame_monitor #(
  parameter int unsigned ColorWidth = 8,
  parameter int unsigned CntWidth   = 12,
  parameter logic        HsyncPol   = 1'b1,
  parameter logic        VsyncPol   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    hsync_i,
  input  logic                    vsync_i,
  input  logic [ColorWidth-1:0]   red_i,
  input  logic [ColorWidth-1:0]   green_i,
  input  logic [ColorWidth-1:0]   blue_i,
  input  logic [CntWidth-1:0]     cfg_h_start_i,
  input  logic [CntWidth-1:0]     cfg_h_active_i,
  input  logic [CntWidth-1:0]     cfg_v_start_i,
  input  logic [CntWidth-1:0]     cfg_v_active_i,
  output logic                    frame_valid_o,
  output logic [31:0]             frame_crc_o,
  output logic [2*CntWidth-1:0]   frame_pix_o,
  output logic [CntWidth-1:0]     h_total_o,
  output logic [CntWidth-1:0]     v_total_o,
  output logic [15:0]             frames_o,
  output logic                    err_o,
  output logic [2:0]              err_code_o
);

  localparam int unsigned PixWidth    = 3 * ColorWidth;
  localparam int unsigned PixCntWidth = 2 * CntWidth;

  typedef enum logic {
    WAIT_VS,
    FRAME
  } state_e;

  // Reflected CRC-32 update, data folded in LSB first.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc,
                                           input logic [PixWidth-1:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < PixWidth; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic                   hs_q, vs_q;
  logic                   hs_edge, vs_edge;
  logic [CntWidth-1:0]    h_q, v_q, h_cur, v_cur, h_len, v_len;
  logic [CntWidth-1:0]    h_last_q;
  logic                   sat_hit;
  logic [CntWidth-1:0]    cfg_h_start_q, cfg_h_active_q, cfg_v_start_q, cfg_v_active_q;
  logic [CntWidth-1:0]    win_h_start, win_h_active, win_v_start, win_v_active;
  logic [CntWidth:0]      h_end, v_end;
  logic                   in_h, in_v, pix_active;
  logic                   frame_start, record_fire;
  logic [31:0]            crc_q, crc_d, crc_base;
  logic [PixCntWidth-1:0] pix_cnt_q, pix_cnt_d, cnt_base, exp_pix;
  logic                   pix_err, line_err;
  logic [2:0]             err_set;

  // Register the sync inputs; reset to the inactive level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q <= ~HsyncPol;
      vs_q <= ~VsyncPol;
    end else begin
      hs_q <= hsync_i;
      vs_q <= vsync_i;
    end
  end

  assign hs_edge = (hsync_i == HsyncPol) && (hs_q != HsyncPol);
  assign vs_edge = (vsync_i == VsyncPol) && (vs_q != VsyncPol);

  // Current-cycle coordinates with saturating counters.
  always_comb begin
    h_len   = (&h_q) ? h_q : h_q + 1'b1;
    v_len   = (&v_q) ? v_q : v_q + 1'b1;
    sat_hit = 1'b0;
    h_cur   = h_len;
    if (hs_edge) begin
      h_cur = '0;
    end else if (&h_q) begin
      sat_hit = 1'b1;
    end
    v_cur = v_q;
    if (vs_edge) begin
      v_cur = '0;
    end else if (hs_edge) begin
      v_cur = v_len;
      if (&v_q) sat_hit = 1'b1;
    end
  end

  // Coordinate counters run in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q      <= '0;
      v_q      <= '0;
      h_last_q <= '0;
    end else begin
      h_q <= h_cur;
      v_q <= v_cur;
      if (hs_edge) h_last_q <= h_len;
    end
  end

  // Window configuration is captured at each vsync edge and held for the frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_h_start_q  <= '0;
      cfg_h_active_q <= '0;
      cfg_v_start_q  <= '0;
      cfg_v_active_q <= '0;
    end else if (vs_edge) begin
      cfg_h_start_q  <= cfg_h_start_i;
      cfg_h_active_q <= cfg_h_active_i;
      cfg_v_start_q  <= cfg_v_start_i;
      cfg_v_active_q <= cfg_v_active_i;
    end
  end

  // Active-window test; on the vsync-edge cycle the new frame's cfg applies.
  always_comb begin
    win_h_start  = vs_edge ? cfg_h_start_i  : cfg_h_start_q;
    win_h_active = vs_edge ? cfg_h_active_i : cfg_h_active_q;
    win_v_start  = vs_edge ? cfg_v_start_i  : cfg_v_start_q;
    win_v_active = vs_edge ? cfg_v_active_i : cfg_v_active_q;
    h_end        = {1'b0, win_h_start} + {1'b0, win_h_active};
    v_end        = {1'b0, win_v_start} + {1'b0, win_v_active};
    in_h         = (h_cur >= win_h_start) && ({1'b0, h_cur} < h_end);
    in_v         = (v_cur >= win_v_start) && ({1'b0, v_cur} < v_end);
    pix_active   = en_i && ((state_q == FRAME) || vs_edge) && in_h && in_v;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= WAIT_VS;
    else         state_q <= state_d;
  end

  // FSM next state: frame start and record strobes.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    record_fire = 1'b0;
    case (state_q)
      WAIT_VS: begin
        if (en_i && vs_edge) begin
          state_d     = FRAME;
          frame_start = 1'b1;
        end
      end
      FRAME: begin
        if (!en_i) begin
          state_d = WAIT_VS;
        end else if (vs_edge) begin
          record_fire = 1'b1;
          frame_start = 1'b1;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // CRC and pixel count; the edge-cycle pixel belongs to the new frame.
  always_comb begin
    crc_base  = frame_start ? 32'hFFFF_FFFF : crc_q;
    cnt_base  = frame_start ? '0 : pix_cnt_q;
    crc_d     = crc_base;
    pix_cnt_d = cnt_base;
    if (pix_active) begin
      crc_d = crc_fold(crc_base, {red_i, green_i, blue_i});
      if (!(&cnt_base)) pix_cnt_d = cnt_base + 1'b1;
    end
  end

  // CRC and pixel count accumulators.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q     <= '0;
      pix_cnt_q <= '0;
    end else begin
      crc_q     <= crc_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

`ifdef CHESHIRE_VMON_LINE_CHECK_EN
  logic [CntWidth-1:0] ref_len_q;
  logic                ref_valid_q;

  // Compare closing lines against the first complete line of the frame.
  always_comb begin
    line_err = (state_q == FRAME) && en_i && hs_edge && ref_valid_q && (h_len != ref_len_q);
  end

  // Capture the reference length at the first hsync edge after frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_len_q   <= '0;
      ref_valid_q <= 1'b0;
    end else if (frame_start) begin
      ref_valid_q <= 1'b0;
    end else if ((state_q == FRAME) && hs_edge && !ref_valid_q) begin
      ref_len_q   <= h_len;
      ref_valid_q <= 1'b1;
    end
  end
`else
  assign line_err = 1'b0;
`endif

  assign exp_pix = {{CntWidth{1'b0}}, cfg_h_active_q} * {{CntWidth{1'b0}}, cfg_v_active_q};
  assign pix_err = record_fire && (pix_cnt_q != exp_pix);
  assign err_set = {sat_hit, line_err, pix_err};

  // Sticky error bits and frame counter; clear wins over same-cycle updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_code_o <= '0;
      frames_o   <= '0;
    end else if (clear_i) begin
      err_code_o <= '0;
      frames_o   <= '0;
    end else begin
      err_code_o <= err_code_o | err_set;
      if (record_fire && !(&frames_o)) frames_o <= frames_o + 16'd1;
    end
  end

  assign err_o = |err_code_o;

  // Registered result record for the frame that just completed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_valid_o <= 1'b0;
      frame_crc_o   <= '0;
      frame_pix_o   <= '0;
      h_total_o     <= '0;
      v_total_o     <= '0;
    end else begin
      frame_valid_o <= record_fire;
      if (record_fire) begin
        frame_crc_o <= ~crc_q;
        frame_pix_o <= pix_cnt_q;
        h_total_o   <= hs_edge ? h_len : h_last_q;
        v_total_o   <= v_len;
      end
    end
  end

endmodule

// File: tb/tb_cheshire_video_frame_monitor.sv
// Bench for cheshire_video_frame_monitor: table of directed video scenarios
// with hand-computed frame records, plus sequences for reset, mid-frame cfg
// changes and counter saturation.
module tb_cheshire_video_frame_monitor;

  localparam logic [2:0] LineErr =
`ifdef CHESHIRE_VMON_LINE_CHECK_EN
    3'b010;
`else
    3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, clear, hsync, vsync;
  logic [7:0]  red, green, blue;
  logic [11:0] cfg_hs, cfg_ha, cfg_vs, cfg_va;
  logic        frame_valid;
  logic [31:0] frame_crc;
  logic [23:0] frame_pix;
  logic [11:0] h_total, v_total;
  logic [15:0] frames;
  logic        err;
  logic [2:0]  err_code;

  int n_cmp  = 0;
  int n_fail = 0;
  int valid_total = 0;

  cheshire_video_frame_monitor dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .clear_i        (clear),
    .hsync_i        (hsync),
    .vsync_i        (vsync),
    .red_i          (red),
    .green_i        (green),
    .blue_i         (blue),
    .cfg_h_start_i  (cfg_hs),
    .cfg_h_active_i (cfg_ha),
    .cfg_v_start_i  (cfg_vs),
    .cfg_v_active_i (cfg_va),
    .frame_valid_o  (frame_valid),
    .frame_crc_o    (frame_crc),
    .frame_pix_o    (frame_pix),
    .h_total_o      (h_total),
    .v_total_o      (v_total),
    .frames_o       (frames),
    .err_o          (err),
    .err_code_o     (err_code)
  );

  always #5 clk = ~clk;

  // Count record pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n && frame_valid) valid_total <= valid_total + 1;
  end

  typedef struct {
    int         hs, ha, vs, va;
    int         nfr, htot, vtot, short_v, short_len, pat, drop_v, clr_fr;
    logic       chk_crc;
    logic [31:0] crc;
    int         pix, h_total, v_total, frames, valids;
    logic [2:0] err;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic sync_lvl);
    rst_n = 1'b0;
    en    = 1'b1;
    clear = 1'b0;
    hsync = sync_lvl;
    vsync = sync_lvl;
    {red, green, blue} = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] pix_of(input int pat, input int h, input int v);
    logic [7:0] k;
    pix_of = {8'(h), 8'(v), 8'(h + 7 * v) ^ 8'hA5};
    if (pat == 0 && v == 1 && h >= 2 && h <= 4) begin
      k = 8'(3 * (h - 2));
      pix_of = {8'h33 + k, 8'h32 + k, 8'h31 + k};
    end
    if (pat == 1 && v == 3 && h == 5) pix_of = 24'h636261;
  endfunction

  // Stream whole frames; hsync active for two cycles per line, vsync for line 0.
  task automatic stream(input int nfr, input int htot, input int vtot, input int short_v,
                        input int short_len, input int pat, input int drop_v, input int clr_fr);
    int len;
    for (int f = 0; f < nfr; f++) begin
      for (int v = 0; v < vtot; v++) begin
        len = (v == short_v) ? short_len : htot;
        for (int h = 0; h < len; h++) begin
          hsync = (h < 2);
          vsync = (v == 0);
          {red, green, blue} = pix_of(pat, h, v);
          en    = !(f == 0 && v == drop_v);
          clear = (f == clr_fr && v == 0 && h == 0);
          tick();
        end
      end
    end
    hsync = 1'b0;
    vsync = 1'b0;
    clear = 1'b0;
    en    = 1'b1;
    {red, green, blue} = '0;
  endtask

  initial begin
    int base;
    string nm;

    //           hs ha vs va  nfr htot vtot shv shl pat drop clr  chk crc           pix ht vt fr val err
    vecs[0] = '{2, 3, 1, 1,  2, 10, 6, -1, 0, 0, -1, -1, 1'b1, 32'hCBF43926, 3, 10, 6, 1, 1, 3'b000};
    vecs[1] = '{2, 3, 1, 2,  2, 10, 6, -1, 0, 0, -1, -1, 1'b0, 32'h0,        6, 10, 6, 1, 1, 3'b000};
    vecs[2] = '{5, 1, 3, 1,  2,  8, 5, -1, 0, 1, -1, -1, 1'b1, 32'h352441C2, 1,  8, 5, 1, 1, 3'b000};
    vecs[3] = '{0, 0, 0, 0,  2,  7, 4, -1, 0, 2, -1, -1, 1'b1, 32'h00000000, 0,  7, 4, 1, 1, 3'b000};
    vecs[4] = '{0, 2, 0, 1,  3, 10, 6, -1, 0, 2, -1, -1, 1'b0, 32'h0,        2, 10, 6, 2, 2, 3'b000};
    vecs[5] = '{2, 3, 1, 1,  2, 10, 6,  3, 9, 0, -1, -1, 1'b1, 32'hCBF43926, 3, 10, 6, 1, 1, LineErr};
    vecs[6] = '{2, 3, 1, 7,  2, 10, 6, -1, 0, 0, -1, -1, 1'b0, 32'h0,       15, 10, 6, 1, 1, 3'b001};
    vecs[7] = '{2, 3, 1, 1,  3, 10, 6, -1, 0, 0,  2, -1, 1'b1, 32'hCBF43926, 3, 10, 6, 1, 1, 3'b000};
    vecs[8] = '{2, 3, 1, 1,  2, 10, 6, -1, 0, 0,  2, -1, 1'b1, 32'h00000000, 0,  0, 0, 0, 0, 3'b000};
    vecs[9] = '{2, 3, 1, 7,  2, 10, 6, -1, 0, 0, -1,  1, 1'b0, 32'h0,       15, 10, 6, 0, 1, 3'b000};

    cfg_hs = '0; cfg_ha = '0; cfg_vs = '0; cfg_va = '0;

    // Reset state.
    do_reset(1'b0);
    tick();
    check("rst_valid", frame_valid, 0);
    check("rst_crc", frame_crc, 0);
    check("rst_pix", frame_pix, 0);
    check("rst_htot", h_total, 0);
    check("rst_vtot", v_total, 0);
    check("rst_frames", frames, 0);
    check("rst_err", err, 0);
    check("rst_errcode", err_code, 0);
    $display("seq reset: crc=%08h frames=%0d err=%03b", frame_crc, frames, err_code);

    // Table-driven frame scenarios.
    for (int i = 0; i < 10; i++) begin
      do_reset(1'b0);
      cfg_hs = 12'(vecs[i].hs); cfg_ha = 12'(vecs[i].ha);
      cfg_vs = 12'(vecs[i].vs); cfg_va = 12'(vecs[i].va);
      tick();
      base = valid_total;
      stream(vecs[i].nfr, vecs[i].htot, vecs[i].vtot, vecs[i].short_v, vecs[i].short_len,
             vecs[i].pat, vecs[i].drop_v, vecs[i].clr_fr);
      repeat (4) tick();
      nm = $sformatf("v%0d", i);
      if (vecs[i].chk_crc) check({nm, "_crc"}, frame_crc, vecs[i].crc);
      check({nm, "_pix"}, frame_pix, vecs[i].pix);
      check({nm, "_htot"}, h_total, vecs[i].h_total);
      check({nm, "_vtot"}, v_total, vecs[i].v_total);
      check({nm, "_frames"}, frames, vecs[i].frames);
      check({nm, "_valids"}, valid_total - base, vecs[i].valids);
      check({nm, "_errcode"}, err_code, vecs[i].err);
      check({nm, "_err"}, err, |vecs[i].err);
      $display("vec %0d: crc=%08h pix=%0d h=%0d v=%0d frames=%0d records=%0d err=%03b",
               i, frame_crc, frame_pix, h_total, v_total, frames, valid_total - base, err_code);
    end

    // Syncs already active at reset release, no further edges.
    do_reset(1'b1);
    base = valid_total;
    repeat (20) tick();
    check("syncrst_valids", valid_total - base, 0);
    check("syncrst_crc", frame_crc, 0);
    check("syncrst_pix", frame_pix, 0);
    check("syncrst_vtot", v_total, 0);
    check("syncrst_frames", frames, 0);
    check("syncrst_err", err, 0);
    $display("seq sync-at-reset: records=%0d frames=%0d err=%0b", valid_total - base, frames, err);

    // Mid-frame cfg change only takes effect on the following frame.
    do_reset(1'b0);
    cfg_hs = 12'd2; cfg_ha = 12'd3; cfg_vs = 12'd1; cfg_va = 12'd2;
    tick();
    stream(2, 10, 6, -1, 0, 0, -1, -1);
    cfg_va = 12'd7;
    stream(1, 10, 6, -1, 0, 0, -1, -1);
    repeat (3) tick();
    check("cfgchg_pix1", frame_pix, 6);
    check("cfgchg_err1", err_code[0], 0);
    check("cfgchg_frames1", frames, 2);
    stream(1, 10, 6, -1, 0, 0, -1, -1);
    repeat (3) tick();
    check("cfgchg_pix2", frame_pix, 15);
    check("cfgchg_err2", err_code[0], 1);
    check("cfgchg_frames2", frames, 3);
    $display("seq cfg-change: pix=%0d frames=%0d err=%03b", frame_pix, frames, err_code);

    // Horizontal counter saturation without any sync edges.
    do_reset(1'b0);
    base = valid_total;
    repeat (4100) tick();
    check("sat_errcode", err_code, 3'b100);
    check("sat_err", err, 1);
    check("sat_valids", valid_total - base, 0);
    $display("seq saturation: err=%03b records=%0d", err_code, valid_total - base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
